// File: rtl/esp_uart_flow_uart.sv
// Buffered UART for the ESP8266 link. The TX and RX FIFOs sit behind RTS/CTS flow control
// implemented in fabric. Each frame has one start bit, DATA_BITS data bits sent LSB first,
// one stop bit and no parity.
module esp_uart_flow_uart #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned BAUD       = 115_200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned RTS_THRESH = 12
) (
   input  logic                            sysclk,
   input  logic                            sysreset_n,
   input  logic                            flow_en,
   input  logic [DATA_BITS-1:0]            tx_data,
   input  logic                            tx_valid,
   output logic                            tx_ready,
   output logic [DATA_BITS-1:0]            rx_data,
   output logic                            rx_valid,
   input  logic                            rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]     tx_level,
   output logic [$clog2(FIFO_DEPTH):0]     rx_level,
   output logic                            rx_overrun,
   output logic                            frame_err,
   input  logic                            err_clr,
   output logic                            uart_txd,
   input  logic                            uart_rxd,
   output logic                            uart_rts_n,
   input  logic                            uart_cts_n
);

   localparam int unsigned DIV = CLK_HZ / BAUD;
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned LW  = AW + 1;
   localparam int unsigned CW  = $clog2(DIV) + 1;
   localparam int unsigned BW  = $clog2(DATA_BITS) + 1;

   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
   localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);
   localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] RTS_L     = LW'(RTS_THRESH);

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_st_e;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_st_e;

   // ---------------------------------------------------------------------------------------
   // Input synchronisers and the ready gate
   // ---------------------------------------------------------------------------------------
   logic [1:0] rxd_sync_q, cts_sync_q;
   logic       rxd_sync, cts_sync;
   logic       alive_q;

   // Two-flop synchronisers; they reset to the line-idle level.
   always_ff @(posedge sysclk or negedge sysreset_n) begin
      if (!sysreset_n) begin
         rxd_sync_q <= 2'b11;
         cts_sync_q <= 2'b11;
         alive_q    <= 1'b0;
      end else begin
         rxd_sync_q <= {rxd_sync_q[0], uart_rxd};
         cts_sync_q <= {cts_sync_q[0], uart_cts_n};
         alive_q    <= 1'b1;
      end
   end

   assign rxd_sync = rxd_sync_q[1];
   assign cts_sync = cts_sync_q[1];

   // ---------------------------------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------------------------------
   logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
   logic [LW-1:0]        tx_wr_q, tx_rd_q;
   logic                 tx_full, tx_empty, tx_push, tx_pop;
   logic [DATA_BITS-1:0] tx_head;

   assign tx_level = tx_wr_q - tx_rd_q;
   assign tx_full  = (tx_level == DEPTH_L);
   assign tx_empty = (tx_level == '0);
   assign tx_ready = alive_q && !tx_full;
   assign tx_push  = tx_valid && tx_ready;
   assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];

   // TX storage write
   always_ff @(posedge sysclk) begin
      if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= tx_data;
   end

   // TX pointers; the extra MSB tells full from empty
   always_ff @(posedge sysclk or negedge sysreset_n) begin
      if (!sysreset_n) begin
         tx_wr_q <= '0;
         tx_rd_q <= '0;
      end else begin
         if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
         if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------------------
   // TX FSM
   // ---------------------------------------------------------------------------------------
   tx_st_e               tx_st_q, tx_st_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic                 txd_q, txd_d;
   logic                 tx_go;

   // CTS is only consulted when a frame is about to start
   assign tx_go = !tx_empty && (!flow_en || !cts_sync);

   // TX state register; txd is registered so the pin is glitch-free
   always_ff @(posedge sysclk or negedge sysreset_n) begin
      if (!sysreset_n) begin
         tx_st_q  <= TxIdle;
         tx_cnt_q <= '0;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
         txd_q    <= 1'b1;
      end else begin
         tx_st_q  <= tx_st_d;
         tx_cnt_q <= tx_cnt_d;
         tx_bit_q <= tx_bit_d;
         tx_sh_q  <= tx_sh_d;
         txd_q    <= txd_d;
      end
   end

   // TX next state; the stop bit chains straight into the next start bit when data is waiting
   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q + 1'b1;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      txd_d    = txd_q;
      tx_pop   = 1'b0;
      unique case (tx_st_q)
         TxIdle: begin
            tx_cnt_d = '0;
            txd_d    = 1'b1;
            if (tx_go) begin
               tx_pop  = 1'b1;
               tx_sh_d = tx_head;
               txd_d   = 1'b0;
               tx_st_d = TxStart;
            end
         end
         TxStart: begin
            if (tx_cnt_q == DIV_LAST) begin
               tx_cnt_d = '0;
               tx_bit_d = '0;
               txd_d    = tx_sh_q[0];
               tx_st_d  = TxData;
            end
         end
         TxData: begin
            if (tx_cnt_q == DIV_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == BITS_LAST) begin
                  txd_d   = 1'b1;
                  tx_st_d = TxStop;
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
                  tx_sh_d  = tx_sh_q >> 1;
                  txd_d    = tx_sh_q[1];
               end
            end
         end
         TxStop: begin
            if (tx_cnt_q == DIV_LAST) begin
               tx_cnt_d = '0;
               if (tx_go) begin
                  tx_pop  = 1'b1;
                  tx_sh_d = tx_head;
                  txd_d   = 1'b0;
                  tx_st_d = TxStart;
               end else begin
                  txd_d   = 1'b1;
                  tx_st_d = TxIdle;
               end
            end
         end
         default: tx_st_d = TxIdle;
      endcase
   end

   assign uart_txd = txd_q;

   // ---------------------------------------------------------------------------------------
   // RX FIFO
   // ---------------------------------------------------------------------------------------
   logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
   logic [LW-1:0]        rx_wr_q, rx_rd_q;
   logic                 rx_full, rx_pop, rx_push, rx_wr_en;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;

   assign rx_level = rx_wr_q - rx_rd_q;
   assign rx_full  = (rx_level == DEPTH_L);
   assign rx_valid = (rx_level != '0);
   assign rx_pop   = rx_valid && rx_ready;
   // A full FIFO still accepts a push when its head leaves in the same cycle
   assign rx_wr_en = rx_push && (!rx_full || rx_pop);
   assign rx_data  = rx_mem[rx_rd_q[AW-1:0]];

   // RX storage write
   always_ff @(posedge sysclk) begin
      if (rx_wr_en) rx_mem[rx_wr_q[AW-1:0]] <= rx_sh_q;
   end

   // RX pointers
   always_ff @(posedge sysclk or negedge sysreset_n) begin
      if (!sysreset_n) begin
         rx_wr_q <= '0;
         rx_rd_q <= '0;
      end else begin
         if (rx_wr_en) rx_wr_q <= rx_wr_q + 1'b1;
         if (rx_pop)   rx_rd_q <= rx_rd_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------------------
   // RX FSM
   // ---------------------------------------------------------------------------------------
   rx_st_e        rx_st_q, rx_st_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [BW-1:0] rx_bit_q, rx_bit_d;
   logic          overrun_q, overrun_d;
   logic          ferr_q, ferr_d;

   // RX state register and error flags
   always_ff @(posedge sysclk or negedge sysreset_n) begin
      if (!sysreset_n) begin
         rx_st_q   <= RxIdle;
         rx_cnt_q  <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_st_q   <= rx_st_d;
         rx_cnt_q  <= rx_cnt_d;
         rx_bit_q  <= rx_bit_d;
         rx_sh_q   <= rx_sh_d;
         overrun_q <= overrun_d;
         ferr_q    <= ferr_d;
      end
   end

   // RX next state; samples land mid-bit by waiting half a bit after the falling edge
   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q + 1'b1;
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      rx_push  = 1'b0;
      ferr_d   = 1'b0;
      unique case (rx_st_q)
         RxIdle: begin
            rx_cnt_d = '0;
            if (!rxd_sync) rx_st_d = RxStart;
         end
         RxStart: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               rx_st_d  = rxd_sync ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rxd_sync, rx_sh_q[DATA_BITS-1:1]};
               if (rx_bit_q == BITS_LAST) rx_st_d = RxStop;
               else                       rx_bit_d = rx_bit_q + 1'b1;
            end
         end
         RxStop: begin
            if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_d = '0;
               if (rxd_sync) begin
                  rx_push = 1'b1;
                  rx_st_d = RxIdle;
               end else begin
                  ferr_d  = 1'b1;
                  rx_st_d = RxWait;
               end
            end
         end
         RxWait: begin
            rx_cnt_d = '0;
            if (rxd_sync) rx_st_d = RxIdle;
         end
         default: rx_st_d = RxIdle;
      endcase
   end

   // Sticky overrun; a new loss wins over a simultaneous clear
   always_comb begin
      overrun_d = overrun_q;
      if (rx_push && rx_full && !rx_pop) overrun_d = 1'b1;
      else if (err_clr)                  overrun_d = 1'b0;
   end

   assign rx_overrun = overrun_q;
   assign frame_err  = ferr_q;

   // ---------------------------------------------------------------------------------------
   // RTS
   // ---------------------------------------------------------------------------------------
   logic rts_n_q;

   // Registered RTS; it follows the RX level one cycle late
   always_ff @(posedge sysclk or negedge sysreset_n) begin
      if (!sysreset_n) rts_n_q <= 1'b1;
      else             rts_n_q <= flow_en ? (rx_level >= RTS_L) : 1'b0;
   end

   assign uart_rts_n = rts_n_q;

endmodule

// File: tb/tb_esp_uart_flow_uart.sv
// Bench for esp_uart_flow_uart: directed flow-control scenarios plus random loopback traffic,
// all checked against queues of expected characters.
module tb_esp_uart_flow_uart;

   localparam int DIV = 16;

   logic       sysclk = 1'b0;
   logic       sysreset_n;
   logic       flow_en;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [2:0] tx_level, rx_level;
   logic       rx_overrun, frame_err, err_clr;
   logic       uart_txd, uart_rxd, uart_rts_n, uart_cts_n;
   logic       rxd_drv, cts_drv, lb;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // External wiring: either bench-driven or looped back
   assign uart_rxd   = lb ? uart_txd : rxd_drv;
   assign uart_cts_n = lb ? uart_rts_n : cts_drv;

   esp_uart_flow_uart #(
      .CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .FIFO_DEPTH(4), .RTS_THRESH(3)
   ) dut (
      .sysclk(sysclk), .sysreset_n(sysreset_n), .flow_en(flow_en),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_level(tx_level), .rx_level(rx_level),
      .rx_overrun(rx_overrun), .frame_err(frame_err), .err_clr(err_clr),
      .uart_txd(uart_txd), .uart_rxd(uart_rxd),
      .uart_rts_n(uart_rts_n), .uart_cts_n(uart_cts_n)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // TX line decoder: frames as {stop, data, start}, plus the start cycle of each
   logic [9:0] tx_got[$];
   int         tx_t[$];
   initial begin
      logic [9:0] fr;
      int t;
      forever begin
         @(negedge sysclk);
         if (uart_txd === 1'b0) begin
            t = cyc;
            repeat (8) @(negedge sysclk);
            fr[0] = uart_txd;
            for (int j = 1; j < 10; j++) begin
               repeat (DIV) @(negedge sysclk);
               fr[j] = uart_txd;
            end
            tx_got.push_back(fr);
            tx_t.push_back(t);
         end
      end
   end

   // Event watcher for RTS lag and frame_err pulse width
   int   lvl3_cyc = 0, rts_rise_cyc = 0, fe_cnt = 0;
   logic [2:0] prev_lvl = '0;
   logic prev_rts = 1'b1;
   always @(negedge sysclk) begin
      if (rx_level == 3'd3 && prev_lvl == 3'd2) lvl3_cyc = cyc;
      if (uart_rts_n && !prev_rts) rts_rise_cyc = cyc;
      if (frame_err) fe_cnt++;
      prev_lvl = rx_level;
      prev_rts = uart_rts_n;
   end

   logic [7:0] rx_exp[$];
   logic [7:0] lb_exp[$];

   task automatic push(input logic [7:0] b);
      int n = 0;
      while (!tx_ready && n < 3000) begin
         @(negedge sysclk);
         n++;
      end
      if (n == 3000) check_val("push_timeout", 0, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge sysclk);
      tx_valid = 1'b0;
   endtask

   task automatic rx_send(input logic [7:0] d, input logic stop);
      rxd_drv = 1'b0;
      repeat (DIV) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
         rxd_drv = d[i];
         repeat (DIV) @(negedge sysclk);
      end
      rxd_drv = stop;
      repeat (DIV) @(negedge sysclk);
      rxd_drv = 1'b1;
      repeat (4) @(negedge sysclk);
   endtask

   task automatic pop_chk(input string tag);
      logic [7:0] e;
      check_val({tag, "_valid"}, rx_valid, 1);
      e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'h00;
      check_val({tag, "_data"}, rx_data, e);
      rx_ready = 1'b1;
      @(negedge sysclk);
      rx_ready = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k = 0;
      while (tx_got.size() < n && k < budget) begin
         @(negedge sysclk);
         k++;
      end
      if (k == budget) check_val("frame_timeout", tx_got.size(), n);
   endtask

   initial begin
      logic [7:0] b [3];
      logic [9:0] fr;
      logic [9:0] a5_frame;
      int hi, fe0;

      sysreset_n = 1'b0;
      flow_en = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
      rxd_drv = 1'b1; cts_drv = 1'b0; lb = 1'b0;
      repeat (4) @(negedge sysclk);
      check_val("rst_txd", uart_txd, 1);
      check_val("rst_rts", uart_rts_n, 1);
      check_val("rst_tx_ready", tx_ready, 0);
      check_val("rst_rx_valid", rx_valid, 0);
      check_val("rst_levels", {tx_level, rx_level}, 0);
      check_val("rst_err", {rx_overrun, frame_err}, 0);
      sysreset_n = 1'b1;
      repeat (5) @(negedge sysclk);

      // 1: latency and exact bit timing of 0xA5
      tx_got.delete(); tx_t.delete();
      a5_frame = {1'b1, 8'hA5, 1'b0};
      push(8'hA5);
      check_val("t1_pre", uart_txd, 1);
      @(negedge sysclk);
      for (int k = 0; k < 10 * DIV; k++) begin
         fr = a5_frame;
         check_val("t1_bit", uart_txd, fr[k / DIV]);
         @(negedge sysclk);
      end
      repeat (DIV) @(negedge sysclk);
      check_val("t1_tx_level", tx_level, 0);

      // 2: CTS hold, release, mid-frame deassert, back-to-back
      cts_drv = 1'b1;
      repeat (4) @(negedge sysclk);
      tx_got.delete(); tx_t.delete();
      for (int i = 0; i < 3; i++) begin
         b[i] = 8'($urandom);
         push(b[i]);
      end
      hi = 0;
      for (int k = 0; k < 40; k++) begin
         if (uart_txd) hi++;
         @(negedge sysclk);
      end
      check_val("t2_hold", hi, 40);
      check_val("t2_level3", tx_level, 3);
      cts_drv = 1'b0;
      hi = 0;
      while (uart_txd && hi < 20) begin
         @(negedge sysclk);
         hi++;
      end
      check_val("t2_start", uart_txd, 0);
      repeat (60) @(negedge sysclk);
      cts_drv = 1'b1;
      wait_frames(1, 300);
      hi = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge sysclk);
         if (uart_txd) hi++;
      end
      check_val("t2_held_after", hi, 40);
      check_val("t2_level2", tx_level, 2);
      check_val("t2_nframes", tx_got.size(), 1);
      cts_drv = 1'b0;
      wait_frames(3, 600);
      for (int i = 0; i < 3; i++) begin
         fr = (tx_got.size() > 0) ? tx_got.pop_front() : 10'h0;
         check_val("t2_frame", fr, {1'b1, b[i], 1'b0});
      end
      if (tx_t.size() == 3) check_val("t2_b2b", tx_t[2] - tx_t[1], 10 * DIV);
      else check_val("t2_tcount", tx_t.size(), 3);

      // 3: RX fill, RTS watermark, overrun, drain
      for (int i = 0; i < 5; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         if (i < 4) rx_exp.push_back(d);
         rx_send(d, 1'b1);
         if (i == 1) begin
            check_val("t3_level2", rx_level, 2);
            check_val("t3_rts_low", uart_rts_n, 0);
         end
         if (i == 2) begin
            check_val("t3_level3", rx_level, 3);
            check_val("t3_rts_high", uart_rts_n, 1);
            check_val("t3_rts_lag", rts_rise_cyc, lvl3_cyc + 1);
         end
         if (i == 3) begin
            check_val("t3_level4", rx_level, 4);
            check_val("t3_no_ovr", rx_overrun, 0);
         end
      end
      check_val("t3_ovr", rx_overrun, 1);
      check_val("t3_level_full", rx_level, 4);
      err_clr = 1'b1;
      @(negedge sysclk);
      err_clr = 1'b0;
      check_val("t3_ovr_clr", rx_overrun, 0);
      pop_chk("t3_pop1");
      repeat (2) @(negedge sysclk);
      check_val("t3_lvl_p1", rx_level, 3);
      check_val("t3_rts_p1", uart_rts_n, 1);
      pop_chk("t3_pop2");
      repeat (2) @(negedge sysclk);
      check_val("t3_rts_p2", uart_rts_n, 0);
      pop_chk("t3_pop3");
      pop_chk("t3_pop4");
      check_val("t3_empty", rx_valid, 0);

      // 4: framing error and start-bit glitch
      b[0] = 8'($urandom);
      rx_exp.push_back(b[0]);
      rx_send(b[0], 1'b1);
      fe0 = fe_cnt;
      rx_send(8'($urandom), 1'b0);
      check_val("t4_fe_pulse", fe_cnt - fe0, 1);
      check_val("t4_level", rx_level, 1);
      rxd_drv = 1'b0;
      repeat (5) @(negedge sysclk);
      rxd_drv = 1'b1;
      repeat (40) @(negedge sysclk);
      check_val("t4_glitch_lvl", rx_level, 1);
      check_val("t4_glitch_fe", fe_cnt - fe0, 1);
      pop_chk("t4_pop");

      // 5: flow control disabled
      flow_en = 1'b0;
      cts_drv = 1'b1;
      repeat (3) @(negedge sysclk);
      check_val("t5_rts", uart_rts_n, 0);
      tx_got.delete(); tx_t.delete();
      b[0] = 8'($urandom);
      push(b[0]);
      wait_frames(1, 300);
      fr = (tx_got.size() > 0) ? tx_got.pop_front() : 10'h0;
      check_val("t5_frame", fr, {1'b1, b[0], 1'b0});
      flow_en = 1'b1;
      cts_drv = 1'b0;
      repeat (3) @(negedge sysclk);

      // 6: reset mid-TX and mid-RX, then loopback
      b[0] = 8'($urandom);
      rx_exp.push_back(b[0]);
      rx_send(b[0], 1'b1);
      push(8'h00);
      repeat (10) @(negedge sysclk);
      rxd_drv = 1'b0;
      repeat (20) @(negedge sysclk);
      check_val("t6_pre_txd", uart_txd, 0);
      check_val("t6_pre_valid", rx_valid, 1);
      #1 sysreset_n = 1'b0;
      #1;
      check_val("t6_txd", uart_txd, 1);
      check_val("t6_rts", uart_rts_n, 1);
      check_val("t6_ready", tx_ready, 0);
      check_val("t6_valid", rx_valid, 0);
      check_val("t6_levels", {tx_level, rx_level}, 0);
      check_val("t6_err", {rx_overrun, frame_err}, 0);
      @(negedge sysclk);
      rxd_drv = 1'b1;
      rx_exp.delete();
      repeat (2) @(negedge sysclk);
      sysreset_n = 1'b1;
      lb = 1'b1;
      repeat (200) @(negedge sysclk);
      tx_got.delete(); tx_t.delete();

      fork
         begin
            for (int i = 0; i < 12; i++) begin
               logic [7:0] d;
               d = 8'($urandom);
               lb_exp.push_back(d);
               push(d);
            end
         end
         begin
            int got = 0;
            int n = 0;
            while (got < 12 && n < 8000) begin
               @(negedge sysclk);
               n++;
               if (rx_valid && $urandom_range(0, 3) == 0) begin
                  if (lb_exp.size() > 0) check_val("lb_data", rx_data, lb_exp.pop_front());
                  else check_val("lb_extra", 1, 0);
                  got++;
                  rx_ready = 1'b1;
               end else begin
                  rx_ready = 1'b0;
               end
            end
            @(negedge sysclk);
            rx_ready = 1'b0;
            check_val("lb_count", got, 12);
         end
      join
      check_val("lb_ovr", rx_overrun, 0);
      check_val("lb_tx_level", tx_level, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
